// File: rtl/c5_divider.sv
// rtl/c5_divider.sv - iterative radix-2 restoring divider, one quotient bit per clock.
// Optional feature macro: C5_DIVIDER_SIGNED_EN (signed operand support).
module c5_divider #(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_start,
  input  logic             I_signed,
  input  logic [WIDTH-1:0] I_a,
  input  logic [WIDTH-1:0] I_b,
  output logic             O_busy,
  output logic             O_done,
  output logic [WIDTH-1:0] O_quotient,
  output logic [WIDTH-1:0] O_remainder,
  output logic             O_div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

`ifdef C5_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = I_signed & I_a[WIDTH-1];
  assign w_b_neg = I_signed & I_b[WIDTH-1];
  assign w_a_abs = w_a_neg ? (~I_a + 1'b1) : I_a;
  assign w_b_abs = w_b_neg ? (~I_b + 1'b1) : I_b;
  assign w_q_fix = r_neg_q ? (~r_q + 1'b1) : r_q;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = I_signed;
  assign w_a_abs         = I_a;
  assign w_b_abs         = I_b;
  assign w_q_fix         = r_q;
  assign w_r_fix         = r_rem;
`endif

  assign w_accept = (r_state == S_IDLE) && I_start;
  // Trial subtraction in WIDTH+1 bits: bit WIDTH set means a borrow occurred.
  assign w_shift  = {r_rem, r_q[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_div};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (I_start) w_state_nxt = S_CALC;
      S_CALC:   if (r_count == '0) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_a         <= '0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: begin
          if (I_start) begin
            r_count <= CW'(WIDTH - 1);
            r_rem   <= '0;
            r_q     <= w_a_abs;
            r_div   <= w_b_abs;
            r_a     <= I_a;
          end
        end
        S_CALC: begin
          r_count <= r_count - 1'b1;
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], 1'b0};
          end
        end
        S_FINISH: begin
          // A zero divisor bypasses the sign fixup: all-ones quotient, dividend as remainder.
          if (r_div == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign O_busy      = (r_state != S_IDLE);
  assign O_done      = r_done;
  assign O_quotient  = r_quotient;
  assign O_remainder = r_remainder;
  assign O_div_zero  = r_div_zero;

endmodule

// File: tb/tb_c5_divider.sv
// tb/tb_c5_divider.sv - scoreboard bench for c5_divider (both C5_DIVIDER_SIGNED_EN builds).
module tb_c5_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  logic             I_clk;
  logic             I_reset_n;
  logic             I_start;
  logic             I_signed;
  logic [WIDTH-1:0] I_a;
  logic [WIDTH-1:0] I_b;
  logic             O_busy;
  logic             O_done;
  logic [WIDTH-1:0] O_quotient;
  logic [WIDTH-1:0] O_remainder;
  logic             O_div_zero;

  exp_t sb_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  c5_divider #(.WIDTH(WIDTH)) dut (
    .I_clk       (I_clk),
    .I_reset_n   (I_reset_n),
    .I_start     (I_start),
    .I_signed    (I_signed),
    .I_a         (I_a),
    .I_b         (I_b),
    .O_busy      (O_busy),
    .O_done      (O_done),
    .O_quotient  (O_quotient),
    .O_remainder (O_remainder),
    .O_div_zero  (O_div_zero)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;
  always @(posedge I_clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    exp_t e;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa   = a;
    sb   = b;
    e.dz = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef C5_DIVIDER_SIGNED_EN
      if (s) begin
        if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
          e.q = a;
          e.r = '0;
        end else begin
          e.q = sa / sb;
          e.r = sa % sb;
        end
      end
`endif
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, output int t0);
    I_a      = a;
    I_b      = b;
    I_signed = s;
    I_start  = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(negedge I_clk);
    I_start = 1'b0;
    t0      = cyc;
  endtask

  task automatic wait_done(input string tag, input int t0);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20 && !seen; i++) begin
      @(negedge I_clk);
      if (O_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, 32'(cyc - t0), 32'(LAT));
      chk({tag, "_busy_low"}, 32'(O_busy), 32'd0);
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, "_q"}, O_quotient, e.q);
        chk({tag, "_r"}, O_remainder, e.r);
        chk({tag, "_dz"}, 32'(O_div_zero), 32'(e.dz));
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s);
    int t0;
    start_op(a, b, s, t0);
    chk({tag, "_busy_high"}, 32'(O_busy), 32'd1);
    wait_done(tag, t0);
  endtask

  initial begin
    int t0;
    int done_cnt;
    I_reset_n = 1'b0;
    I_start   = 1'b0;
    I_signed  = 1'b0;
    I_a       = '0;
    I_b       = '0;
    repeat (3) @(negedge I_clk);
    chk("rst_busy", 32'(O_busy), 32'd0);
    chk("rst_done", 32'(O_done), 32'd0);
    chk("rst_dz", 32'(O_div_zero), 32'd0);
    chk("rst_q", O_quotient, '0);
    chk("rst_r", O_remainder, '0);
    I_reset_n = 1'b1;
    @(negedge I_clk);

    do_op("u100_7", 32'd100, 32'd7, 1'b0);
    chk("u100_7_q_const", O_quotient, 32'd14);
    chk("u100_7_r_const", O_remainder, 32'd2);
    @(negedge I_clk);
    chk("done_pulse_one_cycle", 32'(O_done), 32'd0);
    chk("q_held", O_quotient, 32'd14);

    do_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
`ifdef C5_DIVIDER_SIGNED_EN
    chk("s_m100_7_q_const", O_quotient, 32'hFFFF_FFF2);
    chk("s_m100_7_r_const", O_remainder, 32'hFFFF_FFFE);
`else
    chk("uns_build_q_const", O_quotient, 32'h2492_4916);
    chk("uns_build_r_const", O_remainder, 32'd2);
`endif
    do_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);

    do_op("u5_0", 32'd5, 32'd0, 1'b0);
    do_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
    chk("s_m5_0_r_const", O_remainder, 32'hFFFF_FFFB);
    do_op("u9_3", 32'd9, 32'd3, 1'b0);
    chk("u9_3_dz_clear", 32'(O_div_zero), 32'd0);

    do_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);

    start_op(32'd100, 32'd7, 1'b0, t0);
    repeat (9) @(negedge I_clk);
    I_a     = 32'd20;
    I_b     = 32'd6;
    I_start = 1'b1;
    @(negedge I_clk);
    I_start = 1'b0;
    chk("ignored_start_busy", 32'(O_busy), 32'd1);
    wait_done("busy_start_ignored", t0);
    start_op(32'd20, 32'd6, 1'b0, t0);
    chk("b2b_busy_high", 32'(O_busy), 32'd1);
    wait_done("b2b_20_6", t0);
    chk("b2b_q_const", O_quotient, 32'd3);

    start_op(32'd1000, 32'd3, 1'b0, t0);
    repeat (4) @(negedge I_clk);
    I_reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(O_busy), 32'd0);
    chk("midrst_done", 32'(O_done), 32'd0);
    chk("midrst_dz", 32'(O_div_zero), 32'd0);
    chk("midrst_q", O_quotient, '0);
    chk("midrst_r", O_remainder, '0);
    sb_q.delete();
    @(negedge I_clk);
    I_reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge I_clk);
      if (O_done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    do_op("u50_5", 32'd50, 32'd5, 1'b0);
    chk("u50_5_q_const", O_quotient, 32'd10);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
